// File: rtl/otp_auth_engine_pkg.sv
// Shared types and constants for the OTP authentication engine.
// Contents:
//   state_t      - top-level FSM states
//   DEFAULT_SEED - LFSR reset/recovery value for the 16-bit default build
//   DEFAULT_TAPS - Galois feedback mask for the 16-bit default build
//   cnt_width()  - register width able to hold the values 0 .. n-1
package otp_auth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        PASS,
        FAIL,
        LOCKED
    } state_t;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;

    // Width of a counter that must reach n-1. Never returns 0, so a limit
    // of 1 still yields a legal one-bit register.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/otp_auth_engine_if.sv
// Handshake/status bundle between the pad-level wrapper and the engine.
// Signals:
//   user_in     - nibble the user is entering
//   otp_latch   - level; a rise requests a new OTP
//   user_latch  - level; a rise commits user_in as the next digit
//   otp_value   - current OTP, MS nibble = first digit (0 when none valid)
//   entry_value - digits entered so far, left-aligned
//   digit_cnt   - number of digits entered
//   tries_used  - failed attempts since the last pass/unlock
//   pass/fail/locked - result flags
// Modports: master (wrapper side), slave (engine side).
interface otp_auth_engine_if
    import otp_auth_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int MAX_TRIES = 3
);
    localparam int CNT_W = cnt_width(DIGITS + 1);
    localparam int TRY_W = cnt_width(MAX_TRIES + 1);

    logic [3:0]          user_in;
    logic                otp_latch;
    logic                user_latch;
    logic [4*DIGITS-1:0] otp_value;
    logic [4*DIGITS-1:0] entry_value;
    logic [CNT_W-1:0]    digit_cnt;
    logic [TRY_W-1:0]    tries_used;
    logic                pass;
    logic                fail;
    logic                locked;

    modport master (
        output user_in, otp_latch, user_latch,
        input  otp_value, entry_value, digit_cnt, tries_used, pass, fail, locked
    );

    modport slave (
        input  user_in, otp_latch, user_latch,
        output otp_value, entry_value, digit_cnt, tries_used, pass, fail, locked
    );

endinterface

// File: rtl/otp_auth_engine_lfsr.sv
// Free-running right-shifting Galois LFSR.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high; loads SEED
//   q     - current register value
// The register steps every cycle. An all-zero state (only reachable through
// an upset, since the seed is nonzero) reloads SEED on the next edge.
module galois_lfsr
    import otp_auth_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] TAPS = W'(DEFAULT_TAPS),
    parameter logic [W-1:0] SEED = W'(DEFAULT_SEED)
) (
    input  logic         clk,
    input  logic         reset,
    output logic [W-1:0] q
);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ TAPS;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/otp_auth_engine.sv
// One-time-passcode authentication engine.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-high
//   bus   - otp_auth_engine_if.slave: latch inputs, digit input, OTP/entry
//           values, digit/attempt counters and pass/fail/locked flags
// A free-running LFSR supplies the OTP on an otp_latch rise; the user keys
// DIGITS nibbles on user_latch rises, the entry is compared in CHECK, and
// MAX_TRIES consecutive failures (mismatch or entry timeout) lock the block
// for LOCK_CYC cycles.
module otp_auth_engine
    import otp_auth_pkg::*;
#(
    parameter int                DIGITS      = 4,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED        = LFSR_W'(DEFAULT_SEED),
    parameter int                MAX_TRIES   = 3,
    parameter int                TIMEOUT_CYC = 1000000,
    parameter int                LOCK_CYC    = 5000000
) (
    input logic               clk,
    input logic               reset,
    otp_auth_engine_if.slave  bus
);

    localparam int OTP_W = 4 * DIGITS;
    localparam int CNT_W = cnt_width(DIGITS + 1);
    localparam int TRY_W = cnt_width(MAX_TRIES + 1);
    localparam int TMR_W = cnt_width(TIMEOUT_CYC);
    localparam int LCK_W = cnt_width(LOCK_CYC);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT  = TRY_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [LCK_W-1:0] LCK_LAST   = LCK_W'(LOCK_CYC - 1);

    logic [LFSR_W-1:0] lfsr_q;

    galois_lfsr #(
        .W    (LFSR_W),
        .TAPS (LFSR_TAPS),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    state_t           state_q, state_d;
    logic [OTP_W-1:0] otp_q, otp_d;
    logic [OTP_W-1:0] entry_q, entry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [LCK_W-1:0] lck_q, lck_d;
    logic             force_fail_q, force_fail_d;
    logic             otp_latch_q, user_latch_q;

    logic             otp_rise;
    logic             user_rise;
    logic [TRY_W-1:0] tries_inc;

    // Rise = level high now, low at the previous edge. The delayed copies
    // update in every state, so a latch held high through LOCKED -> IDLE
    // is not seen as a new request.
    assign otp_rise  = bus.otp_latch  & ~otp_latch_q;
    assign user_rise = bus.user_latch & ~user_latch_q;
    assign tries_inc = tries_q + TRY_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            otp_q        <= '0;
            entry_q      <= '0;
            cnt_q        <= '0;
            tries_q      <= '0;
            tmr_q        <= '0;
            lck_q        <= '0;
            force_fail_q <= 1'b0;
            otp_latch_q  <= 1'b0;
            user_latch_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            otp_q        <= otp_d;
            entry_q      <= entry_d;
            cnt_q        <= cnt_d;
            tries_q      <= tries_d;
            tmr_q        <= tmr_d;
            lck_q        <= lck_d;
            force_fail_q <= force_fail_d;
            otp_latch_q  <= bus.otp_latch;
            user_latch_q <= bus.user_latch;
        end
    end

    always_comb begin
        state_d      = state_q;
        otp_d        = otp_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        tries_d      = tries_q;
        tmr_d        = tmr_q;
        lck_d        = lck_q;
        force_fail_d = force_fail_q;

        case (state_q)
            IDLE, PASS, FAIL: begin
                // tries_q is deliberately left alone so FAIL history carries
                // into the next attempt.
                if (otp_rise) begin
                    otp_d        = lfsr_q[OTP_W-1:0];
                    entry_d      = '0;
                    cnt_d        = '0;
                    tmr_d        = '0;
                    force_fail_d = 1'b0;
                    state_d      = ENTRY;
                end
            end

            ENTRY: begin
                // A digit always wins over both a simultaneous otp_latch rise
                // (ignored here) and a timeout on the same edge.
                if (user_rise) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            entry_d[4*(DIGITS-1-i) +: 4] = bus.user_in;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    tmr_d = '0;
                    if (cnt_q == LAST_DIGIT) begin
                        state_d = CHECK;
                    end
                end else if (tmr_q == TMR_LAST) begin
                    force_fail_d = 1'b1;
                    state_d      = CHECK;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            CHECK: begin
                if ((entry_q == otp_q) && !force_fail_q) begin
                    tries_d = '0;
                    state_d = PASS;
                end else if (tries_inc == TRY_LIMIT) begin
                    // Drop the stale code and entry so nothing leaks once
                    // the lock expires and the block returns to IDLE.
                    tries_d = tries_inc;
                    otp_d   = '0;
                    entry_d = '0;
                    cnt_d   = '0;
                    lck_d   = '0;
                    state_d = LOCKED;
                end else begin
                    tries_d = tries_inc;
                    state_d = FAIL;
                end
            end

            LOCKED: begin
                if (lck_q == LCK_LAST) begin
                    tries_d = '0;
                    state_d = IDLE;
                end else begin
                    lck_d = lck_q + LCK_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.otp_value   = (state_q == LOCKED) ? '0 : otp_q;
    assign bus.entry_value = (state_q == LOCKED) ? '0 : entry_q;
    assign bus.digit_cnt   = cnt_q;
    assign bus.tries_used  = tries_q;
    assign bus.pass        = (state_q == PASS);
    assign bus.fail        = (state_q == FAIL);
    assign bus.locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_otp_auth_engine.sv
// Directed testbench for otp_auth_engine: a 4-digit/16-bit build and a
// 2-digit/8-bit build, with TIMEOUT_CYC=50 and LOCK_CYC=20.
module tb_otp_auth_engine;
    import otp_auth_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    otp_auth_engine_if #(.DIGITS(4), .MAX_TRIES(3)) bus1 ();
    otp_auth_engine_if #(.DIGITS(2), .MAX_TRIES(3)) bus2 ();

    otp_auth_engine #(
        .DIGITS(4), .LFSR_W(16), .LFSR_TAPS(16'hB400), .SEED(16'hACE1),
        .MAX_TRIES(3), .TIMEOUT_CYC(50), .LOCK_CYC(20)
    ) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1.slave)
    );

    otp_auth_engine #(
        .DIGITS(2), .LFSR_W(8), .LFSR_TAPS(8'hB8), .SEED(8'hE1),
        .MAX_TRIES(3), .TIMEOUT_CYC(50), .LOCK_CYC(20)
    ) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2.slave)
    );

    // Reference LFSR for the 16-bit build: right-shift Galois, mask B400.
    logic [15:0] m_lfsr;
    always @(posedge clk or posedge rst) begin
        if (rst)                m_lfsr <= 16'hACE1;
        else if (m_lfsr == '0)  m_lfsr <= 16'hACE1;
        else if (m_lfsr[0])     m_lfsr <= (m_lfsr >> 1) ^ 16'hB400;
        else                    m_lfsr <= m_lfsr >> 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key1(input logic [3:0] d);
        bus1.user_in    = d;
        bus1.user_latch = 1'b1;
        step(1);
        bus1.user_latch = 1'b0;
        step(1);
    endtask

    // The value captured at the next edge is the model value right now.
    task automatic press1(output logic [15:0] e);
        e = m_lfsr;
        bus1.otp_latch = 1'b1;
        step(1);
        bus1.otp_latch = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        step(2);
        n_tests++; if (bus1.otp_value !== 16'h0) begin n_fail++; $display("FAIL reset_otp: got %h want 0000", bus1.otp_value); end
        n_tests++; if (bus1.entry_value !== 16'h0) begin n_fail++; $display("FAIL reset_entry: got %h want 0000", bus1.entry_value); end
        n_tests++; if (bus1.digit_cnt !== 3'd0 || bus1.tries_used !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: cnt=%0d tries=%0d want 0/0", bus1.digit_cnt, bus1.tries_used); end
        n_tests++; if ({bus1.pass, bus1.fail, bus1.locked} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {bus1.pass, bus1.fail, bus1.locked}); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_first_otp();
        bus1.otp_latch = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1);
        n_tests++; if (bus1.otp_value !== 16'hACE1) begin n_fail++; $display("FAIL first_otp: got %h want ace1", bus1.otp_value); end
        n_tests++; if (dut1.state_q !== ENTRY) begin n_fail++; $display("FAIL first_state: got %0d want %0d", dut1.state_q, ENTRY); end
        n_tests++; if (bus1.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL first_cnt: got %0d want 0", bus1.digit_cnt); end
        bus1.otp_latch = 1'b0;
        step(1);
        $display("[TB] test_first_otp done");
    endtask

    task automatic test_pass();
        key1(4'hA);
        n_tests++; if (bus1.entry_value !== 16'hA000 || bus1.digit_cnt !== 3'd1) begin n_fail++; $display("FAIL pass_entry1: entry=%h cnt=%0d want a000/1", bus1.entry_value, bus1.digit_cnt); end
        key1(4'hC);
        key1(4'hE);
        bus1.user_in = 4'h1; bus1.user_latch = 1'b1;
        step(1);
        n_tests++; if (bus1.entry_value !== 16'hACE1 || bus1.digit_cnt !== 3'd4) begin n_fail++; $display("FAIL pass_entry4: entry=%h cnt=%0d want ace1/4", bus1.entry_value, bus1.digit_cnt); end
        n_tests++; if (bus1.pass !== 1'b0) begin n_fail++; $display("FAIL pass_early: pass=%b want 0 in check cycle", bus1.pass); end
        bus1.user_latch = 1'b0;
        step(1);
        n_tests++; if (bus1.pass !== 1'b1 || bus1.fail !== 1'b0 || bus1.tries_used !== 2'd0) begin n_fail++; $display("FAIL pass_flag: pass=%b fail=%b tries=%0d want 1/0/0", bus1.pass, bus1.fail, bus1.tries_used); end
        $display("[TB] test_pass done");
    endtask

    task automatic test_fail();
        logic [15:0] e;
        e = m_lfsr;
        bus1.otp_latch = 1'b1;
        step(1);
        n_tests++; if (bus1.pass !== 1'b0 || dut1.state_q !== ENTRY || bus1.otp_value !== e) begin n_fail++; $display("FAIL fail_recapture: pass=%b otp=%h want 0/%h", bus1.pass, bus1.otp_value, e); end
        bus1.otp_latch = 1'b0;
        step(1);
        key1(e[15:12]); key1(e[11:8]); key1(e[7:4]);
        bus1.user_in = ~e[3:0]; bus1.user_latch = 1'b1;
        step(1);
        n_tests++; if (bus1.fail !== 1'b0) begin n_fail++; $display("FAIL fail_early: fail=%b want 0 in check cycle", bus1.fail); end
        bus1.user_latch = 1'b0;
        step(1);
        n_tests++; if (bus1.fail !== 1'b1 || bus1.pass !== 1'b0 || bus1.tries_used !== 2'd1) begin n_fail++; $display("FAIL fail_flag: fail=%b pass=%b tries=%0d want 1/0/1", bus1.fail, bus1.pass, bus1.tries_used); end
        e = m_lfsr;
        bus1.otp_latch = 1'b1;
        step(1);
        n_tests++; if (bus1.fail !== 1'b0 || dut1.state_q !== ENTRY || bus1.tries_used !== 2'd1) begin n_fail++; $display("FAIL fail_clear: fail=%b tries=%0d want 0/1", bus1.fail, bus1.tries_used); end
        n_tests++; if (bus1.otp_value !== e || bus1.entry_value !== 16'h0 || bus1.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL fail_fresh: otp=%h entry=%h cnt=%0d want %h/0000/0", bus1.otp_value, bus1.entry_value, bus1.digit_cnt, e); end
        bus1.otp_latch = 1'b0;
        step(1);
        // Second wrong entry against the OTP captured above.
        key1(~e[15:12]); key1(~e[11:8]); key1(~e[7:4]); key1(~e[3:0]);
        n_tests++; if (bus1.fail !== 1'b1 || bus1.tries_used !== 2'd2) begin n_fail++; $display("FAIL fail_second: fail=%b tries=%0d want 1/2", bus1.fail, bus1.tries_used); end
        $display("[TB] test_fail done");
    endtask

    task automatic test_lockout();
        logic [15:0] e;
        press1(e);
        key1(~e[15:12]); key1(~e[11:8]); key1(~e[7:4]);
        bus1.user_in = ~e[3:0]; bus1.user_latch = 1'b1;
        step(1);
        bus1.user_latch = 1'b0;
        step(1);
        n_tests++; if (bus1.locked !== 1'b1 || bus1.fail !== 1'b0 || bus1.tries_used !== 2'd3) begin n_fail++; $display("FAIL lock_enter: locked=%b fail=%b tries=%0d want 1/0/3", bus1.locked, bus1.fail, bus1.tries_used); end
        n_tests++; if (bus1.otp_value !== 16'h0 || bus1.entry_value !== 16'h0) begin n_fail++; $display("FAIL lock_blank: otp=%h entry=%h want 0000/0000", bus1.otp_value, bus1.entry_value); end
        // Lock entered one edge ago; it lasts 20 cycles in total.
        bus1.otp_latch = 1'b1;
        step(1);
        bus1.user_in = 4'h5; bus1.user_latch = 1'b1;
        step(1);
        n_tests++; if (bus1.locked !== 1'b1 || bus1.otp_value !== 16'h0 || bus1.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL lock_ignore: locked=%b otp=%h cnt=%0d want 1/0000/0", bus1.locked, bus1.otp_value, bus1.digit_cnt); end
        bus1.user_latch = 1'b0;
        step(17);
        n_tests++; if (bus1.locked !== 1'b1) begin n_fail++; $display("FAIL lock_hold: locked=%b want 1 at cycle 19", bus1.locked); end
        step(1);
        n_tests++; if (bus1.locked !== 1'b0 || bus1.tries_used !== 2'd0 || dut1.state_q !== IDLE) begin n_fail++; $display("FAIL lock_release: locked=%b tries=%0d state=%0d want 0/0/%0d", bus1.locked, bus1.tries_used, dut1.state_q, IDLE); end
        step(1);
        n_tests++; if (dut1.state_q !== IDLE || bus1.otp_value !== 16'h0) begin n_fail++; $display("FAIL lock_held_latch: state=%0d otp=%h want %0d/0000", dut1.state_q, bus1.otp_value, IDLE); end
        bus1.otp_latch = 1'b0;
        step(1);
        $display("[TB] test_lockout done");
    endtask

    task automatic test_timeout();
        logic [15:0] e;
        press1(e);
        key1(e[15:12]);
        bus1.user_in = e[11:8]; bus1.user_latch = 1'b1;
        step(1);
        bus1.user_latch = 1'b0;
        step(49);
        n_tests++; if (dut1.state_q !== ENTRY || bus1.fail !== 1'b0 || bus1.digit_cnt !== 3'd2) begin n_fail++; $display("FAIL tmo_before: state=%0d fail=%b cnt=%0d want %0d/0/2", dut1.state_q, bus1.fail, bus1.digit_cnt, ENTRY); end
        step(1);
        n_tests++; if (dut1.state_q !== CHECK) begin n_fail++; $display("FAIL tmo_check: state=%0d want %0d", dut1.state_q, CHECK); end
        step(1);
        n_tests++; if (bus1.fail !== 1'b1 || bus1.tries_used !== 2'd1) begin n_fail++; $display("FAIL tmo_fail: fail=%b tries=%0d want 1/1", bus1.fail, bus1.tries_used); end
        press1(e);
        key1(e[15:12]);
        bus1.user_in = e[11:8]; bus1.user_latch = 1'b1;
        step(1);
        bus1.user_latch = 1'b0;
        step(48);
        bus1.user_in = e[7:4]; bus1.user_latch = 1'b1;
        step(1);
        bus1.user_latch = 1'b0;
        step(1);
        n_tests++; if (dut1.state_q !== ENTRY || bus1.digit_cnt !== 3'd3 || bus1.fail !== 1'b0) begin n_fail++; $display("FAIL tmo_avoided: state=%0d cnt=%0d fail=%b want %0d/3/0", dut1.state_q, bus1.digit_cnt, bus1.fail, ENTRY); end
        key1(e[3:0]);
        n_tests++; if (bus1.pass !== 1'b1 || bus1.tries_used !== 2'd0) begin n_fail++; $display("FAIL tmo_pass: pass=%b tries=%0d want 1/0", bus1.pass, bus1.tries_used); end
        $display("[TB] test_timeout done");
    endtask

    task automatic test_async_reset();
        logic [15:0] e;
        press1(e);
        key1(e[15:12]);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (bus1.otp_value !== 16'h0 || bus1.entry_value !== 16'h0 || bus1.digit_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_entry: otp=%h entry=%h cnt=%0d want 0000/0000/0", bus1.otp_value, bus1.entry_value, bus1.digit_cnt); end
        @(negedge clk);
        rst = 1'b0;
        step(1);
        bus1.otp_latch = 1'b1;
        step(1);
        // One step from ACE1: lsb set, so 5670 ^ B400.
        n_tests++; if (bus1.otp_value !== 16'hE270) begin n_fail++; $display("FAIL rst_lfsr_step: otp=%h want e270", bus1.otp_value); end
        bus1.otp_latch = 1'b0;
        step(1);
        bus1.otp_latch = 1'b1;
        step(1);
        bus1.otp_latch = 1'b0;
        n_tests++; if (bus1.otp_value !== 16'hE270 || dut1.state_q !== ENTRY) begin n_fail++; $display("FAIL entry_otp_ignored: otp=%h want e270", bus1.otp_value); end
        step(1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) press1(e);
            key1(4'h0); key1(4'h0); key1(4'h0); key1(4'h0);
        end
        n_tests++; if (bus1.locked !== 1'b1) begin n_fail++; $display("FAIL rst_prelock: locked=%b want 1", bus1.locked); end
        step(5);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (bus1.locked !== 1'b0 || bus1.tries_used !== 2'd0 || bus1.otp_value !== 16'h0) begin n_fail++; $display("FAIL rst_locked: locked=%b tries=%0d otp=%h want 0/0/0000", bus1.locked, bus1.tries_used, bus1.otp_value); end
        bus1.otp_latch = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(1);
        n_tests++; if (bus1.otp_value !== 16'hACE1 || dut1.state_q !== ENTRY) begin n_fail++; $display("FAIL rst_reseed: otp=%h state=%0d want ace1/%0d", bus1.otp_value, dut1.state_q, ENTRY); end
        bus1.otp_latch = 1'b0;
        step(1);
        $display("[TB] test_async_reset done");
    endtask

    task automatic test_two_digits();
        bus2.otp_latch = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        step(1);
        n_tests++; if (bus2.otp_value !== 8'hE1 || bus2.digit_cnt !== 2'd0) begin n_fail++; $display("FAIL d2_otp: otp=%h cnt=%0d want e1/0", bus2.otp_value, bus2.digit_cnt); end
        bus2.otp_latch = 1'b0;
        step(1);
        bus2.user_in = 4'hE; bus2.user_latch = 1'b1;
        step(1);
        bus2.user_latch = 1'b0;
        step(1);
        n_tests++; if (bus2.entry_value !== 8'hE0 || bus2.digit_cnt !== 2'd1) begin n_fail++; $display("FAIL d2_entry1: entry=%h cnt=%0d want e0/1", bus2.entry_value, bus2.digit_cnt); end
        // Simultaneous otp and user rises: the digit is taken, OTP kept.
        bus2.user_in = 4'h1; bus2.user_latch = 1'b1; bus2.otp_latch = 1'b1;
        step(1);
        n_tests++; if (bus2.entry_value !== 8'hE1 || bus2.digit_cnt !== 2'd2 || bus2.otp_value !== 8'hE1 || bus2.pass !== 1'b0) begin n_fail++; $display("FAIL d2_entry2: entry=%h cnt=%0d otp=%h pass=%b want e1/2/e1/0", bus2.entry_value, bus2.digit_cnt, bus2.otp_value, bus2.pass); end
        bus2.user_latch = 1'b0; bus2.otp_latch = 1'b0;
        step(1);
        n_tests++; if (bus2.pass !== 1'b1 || bus2.fail !== 1'b0) begin n_fail++; $display("FAIL d2_pass: pass=%b fail=%b want 1/0", bus2.pass, bus2.fail); end
        $display("[TB] test_two_digits done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        rst2 = 1'b1;
        bus1.user_in = 4'h0; bus1.otp_latch = 1'b0; bus1.user_latch = 1'b0;
        bus2.user_in = 4'h0; bus2.otp_latch = 1'b0; bus2.user_latch = 1'b0;
        test_reset();
        test_first_otp();
        test_pass();
        test_fail();
        test_lockout();
        test_timeout();
        test_async_reset();
        test_two_digits();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
